uart_tx_frame: RTL and testbench

UART transmitter: serializes a parallel byte into a frame of start bit, data bits (LSB first), optional parity bit and stop bit on a single line.
- Companion to the UART RX path; parity convention matches the RX parity checker (PAR_TYP 0 = even, 1 = odd).
- clk is the bit-rate clock: each frame bit occupies exactly one clk cycle.
- Sits between the system data source (register file / FIFO read side) and the TX pad.

---
 rtl/uart_tx_frame.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_frame.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// Define UART_TX_HOLD_BUF_EN to add a one-entry holding register for back-to-back frames.
module uart_tx_frame #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  busy
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] sh_q, sh_d;
   logic                  par_en_q, par_en_d;
   logic                  par_q, par_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic                  load_in;
   logic                  load_hold;

   // Even parity is the XOR of the data bits; odd parity is its complement.
   function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data, input logic odd);
      parity_bit = odd ? ~(^data) : (^data);
   endfunction

`ifdef UART_TX_HOLD_BUF_EN
   logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
   logic                  hold_pen_q, hold_pen_d;
   logic                  hold_ptyp_q, hold_ptyp_d;
   logic                  full_q, full_d;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      load_in   = 1'b0;
      load_hold = 1'b0;
      case (state_q)
         IDLE: begin
            if (Data_Valid) begin
               state_d = START;
               load_in = 1'b1;
            end
         end
         START:  state_d = DATA;
         DATA: begin
            if (cnt_q == CNT_LAST) state_d = par_en_q ? PARITY : STOP;
         end
         PARITY: state_d = STOP;
         STOP: begin
`ifdef UART_TX_HOLD_BUF_EN
            // A pending byte (buffered, or offered right now with busy low) starts without an idle gap.
            if (full_q) begin
               state_d   = START;
               load_hold = 1'b1;
            end else if (Data_Valid) begin
               state_d = START;
               load_in = 1'b1;
            end else begin
               state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are computed from the next state so TX_OUT/busy leave flops aligned with state_q.
   always_comb begin
      sh_d     = sh_q;
      cnt_d    = cnt_q;
      par_en_d = par_en_q;
      par_d    = par_q;
      tx_d     = 1'b1;
      if (load_in) begin
         sh_d     = P_DATA;
         par_en_d = PAR_EN;
         par_d    = parity_bit(P_DATA, PAR_TYP);
      end
`ifdef UART_TX_HOLD_BUF_EN
      else if (load_hold) begin
         sh_d     = hold_data_q;
         par_en_d = hold_pen_q;
         par_d    = parity_bit(hold_data_q, hold_ptyp_q);
      end
`endif
      case (state_d)
         START: begin
            tx_d  = 1'b0;
            cnt_d = '0;
         end
         DATA: begin
            tx_d  = sh_q[0];
            sh_d  = sh_q >> 1;
            cnt_d = (state_q == DATA) ? cnt_q + CNT_W'(1) : '0;
         end
         PARITY:  tx_d = par_q;
         default: tx_d = 1'b1;
      endcase
   end

`ifdef UART_TX_HOLD_BUF_EN
   always_comb begin
      hold_data_d = hold_data_q;
      hold_pen_d  = hold_pen_q;
      hold_ptyp_d = hold_ptyp_q;
      full_d      = full_q;
      if (load_hold) begin
         full_d = 1'b0;
      end else if (Data_Valid && !full_q && (state_q != IDLE) && !load_in) begin
         hold_data_d = P_DATA;
         hold_pen_d  = PAR_EN;
         hold_ptyp_d = PAR_TYP;
         full_d      = 1'b1;
      end
      busy_d = full_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_data_q <= '0;
         hold_pen_q  <= 1'b0;
         hold_ptyp_q <= 1'b0;
         full_q      <= 1'b0;
      end else begin
         hold_data_q <= hold_data_d;
         hold_pen_q  <= hold_pen_d;
         hold_ptyp_q <= hold_ptyp_d;
         full_q      <= full_d;
      end
   end
`else
   always_comb begin
      busy_d = (state_d != IDLE);
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q    <= '0;
         sh_q     <= '0;
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         sh_q     <= sh_d;
         par_en_q <= par_en_d;
         par_q    <= par_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
      end
   end

   assign TX_OUT = tx_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed and randomized bench for uart_tx_frame; expected line levels come from a frame-list model.
module tb_uart_tx_frame;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] P_DATA = 8'h00;
   logic       Data_Valid = 1'b0;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic       TX_OUT;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   bit exp_q[$];

`ifdef UART_TX_HOLD_BUF_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   uart_tx_frame #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .TX_OUT     (TX_OUT),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   // Frame as a list of line levels: start, data LSB first, parity (if enabled), stop.
   task automatic build(input logic [7:0] d, input bit pen, input bit ptyp);
      int ones;
      ones = 0;
      exp_q.delete();
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(d[i]);
         ones += int'(d[i]);
      end
      if (pen) exp_q.push_back(ptyp ? ((ones % 2) == 0) : ((ones % 2) == 1));
      exp_q.push_back(1'b1);
   endtask

   // Call just after a negedge with the DUT idle. inject_idx pulses Data_Valid=1/P_DATA=FF mid-frame.
   task automatic run_frame(input logic [7:0] d, input bit pen, input bit ptyp, input int inject_idx);
      P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; Data_Valid = 1'b1;
      build(d, pen, ptyp);
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         chk($sformatf("frame_%02h_bit%0d_tx", d, i), TX_OUT, exp_q[i]);
         chk($sformatf("frame_%02h_bit%0d_busy", d, i), busy, !HOLD);
         Data_Valid = (i == inject_idx);
         P_DATA  = (i == inject_idx) ? 8'hFF : 8'($urandom);
         PAR_EN  = 1'($urandom);
         PAR_TYP = 1'($urandom);
      end
      Data_Valid = 1'b0;
      @(negedge clk);
      chk($sformatf("frame_%02h_after_tx", d), TX_OUT, 1'b1);
      chk($sformatf("frame_%02h_after_busy", d), busy, 1'b0);
   endtask

   task automatic idle_check(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk($sformatf("%s_idle%0d_tx", tag, i), TX_OUT, 1'b1);
         chk($sformatf("%s_idle%0d_busy", tag, i), busy, 1'b0);
      end
   endtask

   initial begin
      bit first_q[$];
      logic [7:0] d1, d2;
      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_tx", TX_OUT, 1'b1);
      chk("reset_busy", busy, 1'b0);
      rst = 1'b1;
      idle_check("post_reset", 2);

      // Directed parity cases
      run_frame(8'hA5, 1'b1, 1'b0, -1);
      run_frame(8'hA5, 1'b1, 1'b1, -1);
      run_frame(8'h00, 1'b1, 1'b1, -1);
      run_frame(8'h00, 1'b1, 1'b0, -1);
      run_frame(8'h3C, 1'b0, 1'b0, -1);
      idle_check("directed", 1);

      // Randomized frames with inputs scrambled mid-frame
      for (int k = 0; k < 16; k++) begin
         run_frame(8'($urandom), 1'($urandom), 1'($urandom), -1);
         if ($urandom_range(0, 1) == 1) idle_check("rand_gap", 1);
      end

`ifndef UART_TX_HOLD_BUF_EN
      // Request while busy is ignored
      run_frame(8'h55, 1'b1, 1'b0, 4);
      idle_check("ignore", 4);

      // Level-held Data_Valid: one idle cycle between frames
      d1 = 8'($urandom); d2 = 8'($urandom);
      build(d1, 1'b1, 1'b1);
      first_q = exp_q;
      P_DATA = d1; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
      for (int i = 0; i < first_q.size(); i++) begin
         @(negedge clk);
         chk($sformatf("level1_bit%0d_tx", i), TX_OUT, first_q[i]);
         chk($sformatf("level1_bit%0d_busy", i), busy, 1'b1);
      end
      P_DATA = d2; PAR_EN = 1'b0;
      @(negedge clk);
      chk("level_gap_tx", TX_OUT, 1'b1);
      chk("level_gap_busy", busy, 1'b0);
      build(d2, 1'b0, 1'b1);
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         chk($sformatf("level2_bit%0d_tx", i), TX_OUT, exp_q[i]);
         Data_Valid = 1'b0;
      end
      idle_check("level_end", 2);
`else
      // Holding register: back-to-back frames, third request while full ignored
      build(8'h12, 1'b1, 1'b0);
      first_q = exp_q;
      build(8'h34, 1'b0, 1'b0);
      P_DATA = 8'h12; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
      for (int i = 0; i < first_q.size(); i++) begin
         @(negedge clk);
         chk($sformatf("hold1_bit%0d_tx", i), TX_OUT, first_q[i]);
         chk($sformatf("hold1_bit%0d_busy", i), busy, i >= 4);
         Data_Valid = (i == 3) || (i == 6);
         P_DATA  = (i == 3) ? 8'h34 : 8'h77;
         PAR_EN  = (i == 3) ? 1'b0 : 1'b1;
         PAR_TYP = 1'b1;
      end
      Data_Valid = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         chk($sformatf("hold2_bit%0d_tx", i), TX_OUT, exp_q[i]);
         chk($sformatf("hold2_bit%0d_busy", i), busy, 1'b0);
      end
      idle_check("hold_end", 3);
`endif

      // Asynchronous reset during data bit 4
      P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
      @(negedge clk);
      Data_Valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_reset_busy", busy, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("async_reset_tx", TX_OUT, 1'b1);
      chk("async_reset_busy", busy, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      idle_check("after_abort", 3);
      run_frame(8'h6B, 1'b1, 1'b1, -1);

      // Reset released while Data_Valid is already high
      rst = 1'b0;
      P_DATA = 8'hC3; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
      @(negedge clk);
      chk("dv_in_reset_tx", TX_OUT, 1'b1);
      chk("dv_in_reset_busy", busy, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      run_frame(8'hC3, 1'b0, 1'b0, -1);
      idle_check("final", 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
